// File: rtl/calc_mux_arbiter.sv
// Two-requester round-robin arbiter driving the calculator's shared operand mux.
// Grants are held for a whole packet; per-requester completed-packet counters wrap.
module calc_mux_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_val,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_last,
    output logic             req0_rdy,
    input  logic             req1_val,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_last,
    output logic             req1_rdy,
    output logic             out_val,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_rdy,
    output logic             sel,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic       last_owner_reg, last_owner_next;
    logic [1:0] eop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_owner_next = last_owner_reg;
        eop             = 2'b00;
        sel             = 1'b0;
        busy            = 1'b0;
        out_val         = 1'b0;
        req0_rdy        = 1'b0;
        req1_rdy        = 1'b0;
        case (state_reg)
            IDLE: begin
                // On a tie the requester that did not own the last packet wins
                if (req0_val && req1_val)
                    state_next = last_owner_reg ? OWN0 : OWN1;
                else if (req0_val)
                    state_next = OWN0;
                else if (req1_val)
                    state_next = OWN1;
            end
            OWN0: begin
                busy     = 1'b1;
                out_val  = req0_val;
                req0_rdy = out_rdy;
                if (req0_val && out_rdy && req0_last) begin
                    eop[0]          = 1'b1;
                    last_owner_next = 1'b0;
                    state_next      = req1_val ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                sel      = 1'b1;
                busy     = 1'b1;
                out_val  = req1_val;
                req1_rdy = out_rdy;
                if (req1_val && out_rdy && req1_last) begin
                    eop[1]          = 1'b1;
                    last_owner_next = 1'b1;
                    state_next      = req0_val ? OWN0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Data path is a plain unregistered 2:1 mux steered by the grant
    assign out_data = sel ? req1_data : req0_data;
    assign out_last = sel ? req1_last : req0_last;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cnt_reg <= '0;
                else if (eop[gi])
                    cnt_reg <= cnt_reg + 1'b1;
            end
        end
    endgenerate

    assign pkt_cnt0 = g_cnt[0].cnt_reg;
    assign pkt_cnt1 = g_cnt[1].cnt_reg;

endmodule

// File: doc/calc_mux_arbiter.md
Name: calc_mux_arbiter

Overview:
- Two-requester round-robin arbiter for the function calculator's shared 2:1 operand mux and the single downstream function unit behind it.
- Each requester presents packets of WIDTH-bit beats under valid/ready handshaking.
- The arbiter locks the mux select to one requester for a whole packet, then re-arbitrates.
- It keeps a wrapping completed-packet count for each requester.

Parameters:
- WIDTH, 8, data width of each beat.
- CNT_W, 4, width of each per-requester packet counter.

Ports:
- clk  input  1  system clock; rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_val  input  1  requester 0 beat valid.
- req0_data  input  WIDTH  requester 0 beat data.
- req0_last  input  1  requester 0 final beat of packet.
- req0_rdy  output  1  requester 0 beat accepted this cycle.
- req1_val  input  1  requester 1 beat valid.
- req1_data  input  WIDTH  requester 1 beat data.
- req1_last  input  1  requester 1 final beat of packet.
- req1_rdy  output  1  requester 1 beat accepted this cycle.
- out_val  output  1  beat valid to the function unit.
- out_data  output  WIDTH  selected beat data.
- out_last  output  1  selected last flag.
- out_rdy  input  1  function unit ready.
- sel  output  1  mux select; 0 = requester 0, 1 = requester 1.
- busy  output  1  a packet is in progress.
- pkt_cnt0  output  CNT_W  completed packets from requester 0.
- pkt_cnt1  output  CNT_W  completed packets from requester 1.

Behaviour:
- FSM states: IDLE, OWN0, OWN1. State, priority pointer and counters are registers; all outputs decode from them combinationally.
- Reset (rst_n=0, asynchronous, takes effect immediately, also mid-packet):
  - state=IDLE; last_owner=1, so requester 0 wins the first tie; pkt_cnt0=pkt_cnt1=0.
  - Outputs forced to out_val=0, req0_rdy=req1_rdy=0, sel=0, busy=0.
  - Any partially transferred packet is abandoned.
- IDLE:
  - All rdy=0, out_val=0, sel=0, busy=0.
  - Next state: OWN0 if only req0_val; OWN1 if only req1_val; if both, OWN of the requester that is not last_owner. Otherwise stay in IDLE.
  - Grant latency is 1 cycle from val to first possible transfer.
- OWNn:
  - sel=n; busy=1; out_val=reqn_val; out_data=reqn_data; out_last=reqn_last; reqn_rdy=out_rdy.
  - The non-owner's rdy is 0.
  - Transfer occurs when out_val and out_rdy are both high.
- Packet lock: the owner keeps the mux until a transfer with last=1. The owner dropping val mid-packet does not release the grant, and the other requester waits.
- End of packet (transfer with last=1 in OWNn):
  - pkt_cntn increments, wrapping 2^CNT_W-1 -> 0.
  - last_owner becomes n.
  - Next state is OWN(other) if the other requester's val is high that cycle, otherwise IDLE. This gives back-to-back packets with no bubble when alternating.
- Single-beat packets (val and last on the same beat) are legal.
- Requesters must hold data and last stable while val=1 and rdy=0. The arbiter passes data through unregistered and never duplicates or drops a beat.
- out_rdy low stalls indefinitely; state is unchanged.

Test Plan:
- Reset then req0 alone, 3-beat packet 0x11,0x22,0x33 (last on 0x33), out_rdy=1 -> sel=0; beats appear in order on out_data; pkt_cnt0=1; IDLE after the last beat.
- Both requesters assert in the same IDLE cycle, 1-beat packets 0xA0/0xB0 -> 0xA0 granted first; OWN1 directly on the next cycle with no idle bubble; then 0xB0; pkt_cnt0=pkt_cnt1=1.
- req0 holds a 4-beat packet while req1 waits; out_rdy toggles 1,0,1,0 -> req1_rdy=0 throughout; sel stays 0 for all 4 beats; each beat appears exactly once.
- Both requesters continuously stream 1-beat packets for 8 packets -> grants alternate 0,1,0,1...; each counter reaches 4.
- 17 single-beat packets from req1 with CNT_W=4 -> pkt_cnt1 wraps 15 -> 0 -> 1.
- rst_n pulsed low asynchronously mid-packet in OWN1 -> outputs drop immediately; IDLE, counters 0; the next tie grants requester 0.
